gen_crd_rtn_agg: RTL
====================

Name: gen_crd_rtn_agg

Overview:
- Receiver-side credit return aggregator. It sits at the consumer end of a credit link.
- It collects credits freed by the local buffer (pops) and returns them in batches. The batch output feeds directly into the credit grant inputs (grant value/enable) of the sender-side credit manager.
- A batch is sent when the pending count reaches a threshold, when an idle timeout expires, or on flush.
- The return channel can stall the output through a valid/ready handshake.

Parameters:
- CRD_INIT_AMOUNT, 8, total credits in the loop; upper bound on the pending count.
- MAX_CRD_FREE_VAL, 1, maximum credits freed in one cycle.
- MAX_CRD_GRNT_VAL, 4, maximum credits returned in one batch.
- RTN_THRESH, 4, pending count that triggers a return. Legal range is 1..CRD_INIT_AMOUNT.
- RTN_TIMEOUT, 16, cycles in ACCUM before a forced return. 0 disables the timeout.
- Derived, localparam:
  - CRD_PEND_W = $clog2(CRD_INIT_AMOUNT)+1
  - CRD_FREE_W = $clog2(MAX_CRD_FREE_VAL)+1
  - CRD_GRNT_W = $clog2(MAX_CRD_GRNT_VAL)+1
  - TMR_W = $clog2(RTN_TIMEOUT+1)

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- crd_free_val  in  CRD_FREE_W  credits freed this cycle.
- crd_free_en  in  1  free valid.
- flush  in  1  level; return all pending credits as soon as possible.
- crd_grnt_rdy  in  1  return channel ready.
- crd_grnt_en  out  1  return valid; connects to the manager's grant enable.
- crd_grnt_val  out  CRD_GRNT_W  credits returned; connects to the manager's grant value.
- crd_pend  out  CRD_PEND_W  registered pending-credit count.
- ovf_err  out  1  sticky overflow error.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pend=0; timer=0.
  - crd_grnt_en=0, crd_grnt_val=0, crd_pend=0, ovf_err=0.
  - Credits pending at reset are discarded. The sender-side manager resets in the same domain, so the loop stays consistent.
- Accumulator arithmetic:
  - free = crd_free_en ? crd_free_val : 0.
  - hs = crd_grnt_en & crd_grnt_rdy.
  - pend_next = pend + free - (hs ? crd_grnt_val : 0), computed at CRD_PEND_W+1 bits.
  - If the result exceeds CRD_INIT_AMOUNT: saturate to CRD_INIT_AMOUNT and set ovf_err (sticky until reset).
- trig = (pend_next >= RTN_THRESH) | (flush & pend_next != 0) | timeout_hit.
- States:
  - IDLE: pend==0, timer held at 0.
    - trig → SEND.
    - else pend_next != 0 → ACCUM.
  - ACCUM: timer increments every cycle. timeout_hit = (RTN_TIMEOUT != 0) & (timer == RTN_TIMEOUT-1).
    - trig → SEND.
  - SEND: crd_grnt_en=1.
    - crd_grnt_val is latched on entry as min(pend_next, MAX_CRD_GRNT_VAL). It stays stable while crd_grnt_rdy=0.
    - Frees keep accumulating into pend during the stall; the latched value is not updated.
    - On hs:
      - pend_next == 0 → IDLE.
      - else trig → stay in SEND and re-latch the value from pend_next.
      - else → ACCUM with timer cleared.
- Timer clears on every entry to ACCUM and is held in IDLE and SEND.
- Latency: the free that satisfies trig in cycle t gives crd_grnt_en=1 in cycle t+1.
- crd_grnt_en and crd_grnt_val are register outputs; there is no combinational path from any input.
- crd_grnt_val is never 0 while crd_grnt_en=1. crd_grnt_val=0 whenever crd_grnt_en=0.
- A free and a handshake in the same cycle are both applied in the same update.
- Timing for a single free: pend becomes nonzero at cycle c, and the return fires at cycle c+RTN_TIMEOUT.

Decomposition:
- Shared package gen_crd_pkg:
  - state enum crd_rtn_state_e {IDLE, ACCUM, SEND}.
  - min helper function for the grant value.
  - The gen_crd_mng_top width formulas also move here as functions, so both ends of the link use the same sizing.
- One natural sub-module: gen_crd_rtn_tmr, the timeout counter with clear/enable/hit and a RTN_TIMEOUT parameter. Every other part stays in the top module.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle with pend=3 in SEND → all outputs 0 immediately. After release, state is IDLE and crd_pend=0.
2. Hold crd_grnt_rdy=1 and apply crd_free_en=1, val=1 in cycles 0-3 → crd_grnt_en=1, val=4 for exactly one cycle (cycle 4). crd_pend returns to 0 at cycle 5.
3. Hold crd_grnt_rdy=1 and apply one free at cycle 0 → crd_pend=1 from cycle 1. crd_grnt_en=1, val=1 at cycle 17, then IDLE.
4. Reach the threshold with crd_grnt_rdy=0 held 5 cycles and 2 more frees during the stall → en held, val held at 4, crd_pend=6. When rdy=1: pend goes to 2, state ACCUM, timer restarts from 0.
5. pend=3 in ACCUM, assert flush → next cycle crd_grnt_en=1, val=3. After the handshake, IDLE.
6. Hold crd_grnt_rdy=0 and issue 9 single frees → crd_pend saturates at 8 and ovf_err=1. ovf_err stays 1 after the drain until reset.

Source files
------------

// File: rtl/gen_crd_pkg.sv
// Shared credit-link definitions: return-FSM states and width/min helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package gen_crd_pkg;

  // Return-side FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2
  } crd_rtn_state_e;

  // Width of a counter that must hold 0..max_val inclusive.
  // Both ends of the credit link size their counters with this.
  function automatic int unsigned crd_cnt_w(input int unsigned max_val);
    return $clog2(max_val) + 1;
  endfunction

  // Width of the idle-timeout counter. It never drops below 1 bit, so a
  // disabled timeout (0) still yields a legal vector.
  function automatic int unsigned crd_tmr_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

  // Smaller of two values; used to clip a batch to the per-grant maximum.
  function automatic int unsigned crd_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/gen_crd_rtn_tmr.sv
// Idle-timeout counter for the credit return aggregator.
// Latency: hit is combinational from the registered count (hit on count RTN_TIMEOUT-1).
// Backpressure: none; the counter is cleared and enabled by the owning FSM.
module gen_crd_rtn_tmr
  import gen_crd_pkg::*;
#(
  parameter int unsigned RTN_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tmr_clr_i,
  input  logic tmr_en_i,
  output logic tmr_hit_o
);

  localparam int unsigned TMR_W = crd_tmr_w(RTN_TIMEOUT);
  localparam bit TO_EN = (RTN_TIMEOUT != 0);
  localparam logic [TMR_W-1:0] HIT_VAL = TMR_W'(TO_EN ? RTN_TIMEOUT - 1 : 0);

  logic [TMR_W-1:0] tmr_q, tmr_d;

  // Clear has priority; count only while enabled and the timeout is in use.
  always_comb begin
    tmr_d = tmr_q;
    if (tmr_clr_i) begin
      tmr_d = '0;
    end else if (tmr_en_i && TO_EN) begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign tmr_hit_o = TO_EN && tmr_en_i && (tmr_q == HIT_VAL);

endmodule

// File: rtl/gen_crd_rtn_agg.sv
// Receiver-side credit return aggregator: batches freed credits back to the sender's grant inputs.
// Latency: a free that meets the return condition in cycle t raises crd_grnt_en in cycle t+1.
// Backpressure: crd_grnt_en/crd_grnt_val hold while crd_grnt_rdy=0; frees keep accumulating meanwhile.
module gen_crd_rtn_agg
  import gen_crd_pkg::*;
#(
  parameter  int unsigned CRD_INIT_AMOUNT  = 8,
  parameter  int unsigned MAX_CRD_FREE_VAL = 1,
  parameter  int unsigned MAX_CRD_GRNT_VAL = 4,
  parameter  int unsigned RTN_THRESH       = 4,
  parameter  int unsigned RTN_TIMEOUT      = 16,
  localparam int unsigned CRD_PEND_W = crd_cnt_w(CRD_INIT_AMOUNT),
  localparam int unsigned CRD_FREE_W = crd_cnt_w(MAX_CRD_FREE_VAL),
  localparam int unsigned CRD_GRNT_W = crd_cnt_w(MAX_CRD_GRNT_VAL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CRD_FREE_W-1:0] crd_free_val,
  input  logic                  crd_free_en,
  input  logic                  flush,
  input  logic                  crd_grnt_rdy,
  output logic                  crd_grnt_en,
  output logic [CRD_GRNT_W-1:0] crd_grnt_val,
  output logic [CRD_PEND_W-1:0] crd_pend,
  output logic                  ovf_err
);

  // One extra bit so pend + free cannot wrap before the saturation check.
  localparam int unsigned SUM_W = CRD_PEND_W + 1;
  localparam logic [SUM_W-1:0]      SUM_MAX  = SUM_W'(CRD_INIT_AMOUNT);
  localparam logic [CRD_PEND_W-1:0] PEND_MAX = CRD_PEND_W'(CRD_INIT_AMOUNT);
  localparam logic [CRD_PEND_W-1:0] THRESH   = CRD_PEND_W'(RTN_THRESH);

  crd_rtn_state_e        state_q, state_d;
  logic [CRD_PEND_W-1:0] pend_q, pend_d;
  logic [CRD_GRNT_W-1:0] grnt_val_q, grnt_val_d;
  logic                  grnt_en_q, grnt_en_d;
  logic                  ovf_q, ovf_d;
  logic                  hs;
  logic                  tmr_hit;
  logic                  trig;
  logic [SUM_W-1:0]      pend_sum;
  logic [CRD_GRNT_W-1:0] grnt_lat;

  assign hs = grnt_en_q & crd_grnt_rdy;

  // Pending-count update: a free and a returned batch in the same cycle land together; saturate on overflow.
  always_comb begin
    pend_sum = SUM_W'(pend_q)
             + (crd_free_en ? SUM_W'(crd_free_val) : '0)
             - (hs ? SUM_W'(grnt_val_q) : '0);
    ovf_d = ovf_q;
    if (pend_sum > SUM_MAX) begin
      pend_d = PEND_MAX;
      ovf_d  = 1'b1;
    end else begin
      pend_d = pend_sum[CRD_PEND_W-1:0];
    end
  end

  // Return condition, evaluated on the post-update count. Never fires with
  // nothing pending, so an asserted grant always carries a nonzero value.
  always_comb begin
    trig = (pend_d != '0) &&
           ((pend_d >= THRESH) || flush || tmr_hit);
    grnt_lat = CRD_GRNT_W'(crd_min(32'(pend_d), MAX_CRD_GRNT_VAL));
  end

  // Return FSM: the grant value is captured when a batch is launched and held through any stall.
  always_comb begin
    state_d    = state_q;
    grnt_en_d  = grnt_en_q;
    grnt_val_d = grnt_val_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (trig) begin
          state_d    = SEND;
          grnt_en_d  = 1'b1;
          grnt_val_d = grnt_lat;
        end else if ((state_q == IDLE) && (pend_d != '0)) begin
          state_d = ACCUM;
        end
      end
      SEND: begin
        if (hs) begin
          if (pend_d == '0) begin
            state_d    = IDLE;
            grnt_en_d  = 1'b0;
            grnt_val_d = '0;
          end else if (trig) begin
            grnt_val_d = grnt_lat;
          end else begin
            state_d    = ACCUM;
            grnt_en_d  = 1'b0;
            grnt_val_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        grnt_en_d  = 1'b0;
        grnt_val_d = '0;
      end
    endcase
  end

  // State, count and output registers. Pending credits are dropped on reset;
  // the sender resets in the same domain, keeping the loop consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      grnt_en_q  <= 1'b0;
      grnt_val_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      grnt_en_q  <= grnt_en_d;
      grnt_val_q <= grnt_val_d;
      ovf_q      <= ovf_d;
    end
  end

  // Idle timeout runs only in ACCUM and sits at zero otherwise, so every
  // entry into ACCUM starts a fresh count.
  gen_crd_rtn_tmr #(
    .RTN_TIMEOUT (RTN_TIMEOUT)
  ) u_tmr (
    .clk       (clk),
    .rst_n     (rst_n),
    .tmr_clr_i (state_q != ACCUM),
    .tmr_en_i  (state_q == ACCUM),
    .tmr_hit_o (tmr_hit)
  );

  assign crd_grnt_en  = grnt_en_q;
  assign crd_grnt_val = grnt_val_q;
  assign crd_pend     = pend_q;
  assign ovf_err      = ovf_q;

endmodule
